// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels and ALU drive/return signals of the ALU arbiter
interface alu_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int STAT_W = 8
);
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic [DATA_W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [STAT_W-1:0] rsp_status;
  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_op_1, alu_op_2, alu_result;
  logic [STAT_W-1:0] alu_status;
  logic              busy;
  modport slave (
    input  req0_valid, req0_ctrl, req0_op1, req0_op2,
    input  req1_valid, req1_ctrl, req1_op1, req1_op2,
    input  rsp0_ready, rsp1_ready, alu_result, alu_status,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_status, alu_control, alu_op_1, alu_op_2, busy
  );
  modport master (
    output req0_valid, req0_ctrl, req0_op1, req0_op2,
    output req1_valid, req1_ctrl, req1_op1, req1_op2,
    output rsp0_ready, rsp1_ready, alu_result, alu_status,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_status, alu_control, alu_op_1, alu_op_2, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4,
  parameter int STAT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t            r_state, w_next;
  logic              r_last, r_owner, w_grant, w_accept, w_done;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_op1, r_op2, r_result;
  logic [STAT_W-1:0] r_status;
  always_comb begin
    w_grant  = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
    w_accept = (r_state == IDLE) & (bus.req0_valid | bus.req1_valid);
    w_done   = (r_state == RESP) & (r_owner ? bus.rsp1_ready : bus.rsp0_ready);
    w_next   = (r_state == IDLE) ? (w_accept ? EXEC : IDLE) :
               (r_state == EXEC) ? RESP : (w_done ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_ctrl   <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_status <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_grant;
        r_ctrl  <= w_grant ? bus.req1_ctrl : bus.req0_ctrl;
        r_op1   <= w_grant ? bus.req1_op1  : bus.req0_op1;
        r_op2   <= w_grant ? bus.req1_op2  : bus.req0_op2;
      end
      if (r_state == EXEC) begin
        r_result <= bus.alu_result;
        r_status <= bus.alu_status;
      end
      if (w_done) r_last <= r_owner;
    end
  assign bus.req0_ready  = w_accept & ~w_grant;
  assign bus.req1_ready  = w_accept & w_grant;
  assign bus.rsp0_valid  = (r_state == RESP) & ~r_owner;
  assign bus.rsp1_valid  = (r_state == RESP) & r_owner;
  assign bus.rsp_result  = r_result;
  assign bus.rsp_status  = r_status;
  assign bus.alu_control = r_ctrl;
  assign bus.alu_op_1    = r_op1;
  assign bus.alu_op_2    = r_op2;
  assign bus.busy        = r_state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with a behavioural ALU; per-requester expected queues
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [39:0] exp0[$], exp1[$];
  logic grants[$];
  logic last_done = 1'b1, done = 1'b0;
  logic [1:0] pv = 2'b00;
  int acc0 = 0, acc1 = 0;
  logic [3:0] ops [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0101};

  alu_arbiter_if bus ();
  alu_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Z,V,C,N,align,div0 in bits 7..2
  function automatic logic [39:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic cy, ov, dz;
    cy = 0; ov = 0; dz = 0; r = 0;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32]; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; cy = ~w[32]; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0101: begin dz = (b == 0); r = dz ? 32'hFFFF_FFFF : a / b; end
      default: r = 0;
    endcase
    return {r, r == 32'd0, ov, cy, r[31], 1'b0, dz, 2'b00};
  endfunction

  assign {bus.alu_result, bus.alu_status} = alu_fn(bus.alu_control, bus.alu_op_1, bus.alu_op_2);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic drive(input int n, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    if (n == 0) begin
      bus.req0_ctrl = c; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_valid = 1'b1;
      exp0.push_back(alu_fn(c, a, b));
    end else begin
      bus.req1_ctrl = c; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_valid = 1'b1;
      exp1.push_back(alu_fn(c, a, b));
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n == 0 ? bus.req0_ready : bus.req1_ready) break;
      if (i == 99) begin
        miscompares++;
        $display("FAIL req%0d_accept: no ready within 100 cycles", n);
      end
    end
    @(posedge clk); #1;
    if (n == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n == 0 ? bus.rsp0_valid : bus.rsp1_valid) return;
    end
    miscompares++;
    $display("FAIL rsp%0d_wait: valid not seen within 20 cycles", n);
  endtask

  task automatic rand_drv(input int n, input int cnt);
    logic [31:0] b;
    repeat (cnt) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      drive(n, ops[$urandom_range(0, 4)], $urandom, b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp0.delete(); exp1.delete();
      last_done = 1'b1;
      pv = 2'b00;
    end else begin
      chk("ready_onehot", {63'd0, bus.req0_ready & bus.req1_ready}, 0);
      chk("rsp_onehot", {63'd0, bus.rsp0_valid & bus.rsp1_valid}, 0);
      if (bus.req0_ready | bus.req1_ready) begin
        chk("ready_busy", {63'd0, bus.busy}, 0);
        chk("ready_valid", {62'd0, bus.req1_ready & ~bus.req1_valid, bus.req0_ready & ~bus.req0_valid}, 0);
        if (bus.req0_valid & bus.req1_valid) chk("fairness", {63'd0, bus.req1_ready}, {63'd0, ~last_done});
        grants.push_back(bus.req1_ready);
        if (bus.req0_ready) acc0 = cyc; else acc1 = cyc;
      end
      if (bus.rsp0_valid & ~pv[0]) chk("latency0", cyc - acc0, 2);
      if (bus.rsp1_valid & ~pv[1]) chk("latency1", cyc - acc1, 2);
      if (bus.rsp0_valid & bus.rsp0_ready) begin
        if (exp0.size() == 0) begin miscompares++; $display("FAIL rsp0_unexpected: response with no pending op"); end
        else chk("rsp0_data", {24'd0, bus.rsp_result, bus.rsp_status}, {24'd0, exp0.pop_front()});
        last_done = 1'b0;
      end
      if (bus.rsp1_valid & bus.rsp1_ready) begin
        if (exp1.size() == 0) begin miscompares++; $display("FAIL rsp1_unexpected: response with no pending op"); end
        else chk("rsp1_data", {24'd0, bus.rsp_result, bus.rsp_status}, {24'd0, exp1.pop_front()});
        last_done = 1'b1;
      end
      pv = {bus.rsp1_valid, bus.rsp0_valid};
    end
  end

  initial begin
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_ctrl = 0; bus.req1_ctrl = 0;
    bus.req0_op1 = 0; bus.req0_op2 = 0; bus.req1_op1 = 0; bus.req1_op2 = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {63'd0, bus.busy}, 0);
    chk("reset_rsp_valid", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 0);
    rst_n = 1'b1;
    // contention right after reset: req0 wins the first tie
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    grants.delete();
    fork
      repeat (2) drive(0, 4'b0010, $urandom, $urandom);
      repeat (2) drive(1, 4'b0110, $urandom, $urandom);
    join
    repeat (4) @(posedge clk);
    chk("contention_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("contention_grant%0d", i), {63'd0, grants[i]}, i % 2);
    // single ADD
    drive(0, 4'b0010, 5, 7);
    wait_rsp(0);
    chk("add_result", {32'd0, bus.rsp_result}, 12);
    chk("add_status", {56'd0, bus.rsp_status}, 0);
    @(negedge clk);
    chk("add_idle", {63'd0, bus.busy}, 0);
    // backpressure on requester 1 while requester 0 waits
    bus.rsp1_ready = 0;
    drive(1, 4'b0110, 3, 3);
    wait_rsp(1);
    fork
      drive(0, 4'b0010, 100, 1);
      begin
        repeat (5) begin
          chk("bp_valid", {63'd0, bus.rsp1_valid}, 1);
          chk("bp_result", {32'd0, bus.rsp_result}, 0);
          chk("bp_zero_flag", {63'd0, bus.rsp_status[7]}, 1);
          chk("bp_req0_blocked", {63'd0, bus.req0_ready}, 0);
          @(negedge clk);
        end
        bus.rsp1_ready = 1;
      end
    join
    wait_rsp(0);
    // divide by zero flag passes through
    drive(0, 4'b0101, 9, 0);
    wait_rsp(0);
    chk("div0_flag", {63'd0, bus.rsp_status[2]}, 1);
    // async reset while a response is pending
    bus.rsp1_ready = 0;
    drive(1, 4'b0001, 32'hF0, 32'h0F);
    wait_rsp(1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", {62'd0, bus.rsp1_valid, bus.rsp0_valid}, 0);
    chk("rst_busy", {63'd0, bus.busy}, 0);
    chk("rst_alu_ctrl", {60'd0, bus.alu_control}, 0);
    chk("rst_alu_ops", {bus.alu_op_1, bus.alu_op_2}, 0);
    chk("rst_rsp_data", {24'd0, bus.rsp_result, bus.rsp_status}, 0);
    bus.rsp1_ready = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    grants.delete();
    fork
      drive(0, 4'b0010, 1, 1);
      drive(1, 4'b0010, 2, 2);
    join
    repeat (8) @(posedge clk);
    chk("post_reset_tie", {63'd0, grants[0]}, 0);
    // randomized traffic with random backpressure
    fork
      begin
        fork
          rand_drv(0, 40);
          rand_drv(1, 40);
        join
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        bus.rsp0_ready = $urandom_range(0, 3) != 0;
        bus.rsp1_ready = $urandom_range(0, 3) != 0;
      end
    join
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    for (int i = 0; i < 50 && (exp0.size() != 0 || exp1.size() != 0); i++) @(posedge clk);
    chk("drain_pending", exp0.size() + exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
